uart_rx_checked: RTL and testbench

UART_RX_CHECKED -- requirements
Module: uart_rx_checked

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_rx_checked.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_checked.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_t;

    localparam int UART_DBIT_DEFAULT    = 8;
    localparam int UART_SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator; tick period is dvsr+1 clock cycles.
module uart_baud_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] dvsr,
    output logic        tick
);

    logic [10:0] count_q;
    logic [10:0] count_d;

    // Using >= lets a lowered divisor take effect at once instead of wrapping through 2047.
    assign tick    = (count_q >= dvsr);
    assign count_d = tick ? 11'd0 : count_q + 11'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 11'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_checked.sv
// Oversampling UART receiver with optional parity, frame/break detection and a one-deep
// valid/ready output register that reports overrun when a finished frame cannot be held.
module uart_rx_checked
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT_DEFAULT,
    parameter int SB_TICK = UART_SB_TICK_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [10:0]     dvsr,
    input  logic            rx,
    input  logic            parity_en,
    input  logic            parity_odd,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            parity_err,
    output logic            break_det,
    output logic            overrun
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic tick;

    uart_baud_gen u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .dvsr    (dvsr),
        .tick    (tick)
    );

    logic sync1_q, sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_en_q, par_en_d;
    logic            par_odd_q, par_odd_d;
    logic            par_bit_q, par_bit_d;
    logic            done;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    s_d       = '0;
                    par_en_d  = parity_en;
                    par_odd_d = parity_odd;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d       = '0;
                        par_bit_d = rx_s;
                        state_d   = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done    = 1'b1;
                        s_d     = '0;
                        state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Flags are evaluated from the stop-bit sample itself, in the completion cycle.
    logic new_frame_err, new_par_err, new_break;

    assign new_frame_err = !rx_s;
    assign new_par_err   = par_en_q && ((^b_q ^ par_bit_q) != par_odd_q);
    assign new_break     = (b_q == '0) && !(par_en_q && par_bit_q) && !rx_s;

    logic [DBIT-1:0] rx_data_q;
    logic            rx_valid_q, frame_err_q, parity_err_q, break_det_q, overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= done && rx_valid_q && !rx_ready;
            if (done && (!rx_valid_q || rx_ready)) begin
                rx_data_q    <= b_q;
                frame_err_q  <= new_frame_err;
                parity_err_q <= new_par_err;
                break_det_q  <= new_break;
                rx_valid_q   <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Directed bench for uart_rx_checked: frames are bit-banged on rx and outputs compared
// against hand-computed values.
module tb_uart_rx_checked;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] dvsr = 11'd3;
    logic        rx = 1'b1;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, parity_err, break_det, overrun;

    int checks = 0;
    int errors = 0;
    int ov_count = 0;
    logic [7:0] got_q[$];

    uart_rx_checked dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dvsr       (dvsr),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .break_det  (break_det),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Record overrun pulse cycles and every accepted byte.
    always @(negedge clk) begin
        if (overrun) ov_count++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic hold_bits(input int nbits);
        repeat (nbits * 16 * (int'(dvsr) + 1)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            hold_bits(1);
        end
        if (with_par) begin
            rx = par_bit;
            hold_bits(1);
        end
        rx = stop_bit;
        hold_bits(1);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < 40000 && !rx_valid; n++) @(negedge clk);
        if (!rx_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout rx_valid got 0 want 1", name);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL reset_break got %b want 0", break_det); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, ST_IDLE); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_basic();
        dvsr = 11'd53;
        parity_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        wait_valid("basic");
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data got %h want 55", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL basic_parity_err got %b want 0", parity_err); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL basic_break got %b want 0", break_det); end
        consume();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL consume_data_kept got %h want 55", rx_data); end
        dvsr = 11'd3;
        hold_bits(1);
    endtask

    task automatic test_parity();
        parity_en = 1'b1;
        parity_odd = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_valid("par_odd_bad");
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL par_odd_bad_data got %h want a5", rx_data); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_odd_bad_err got %b want 1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_odd_bad_frame got %b want 0", frame_err); end
        consume();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_valid("par_odd_good");
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_odd_good_err got %b want 0", parity_err); end
        consume();
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        wait_valid("par_even_bad");
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_even_data got %h want 07", rx_data); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_even_err got %b want 1", parity_err); end
        consume();
        // All-zero data with a set parity bit and a low stop bit is a framing error, not a break.
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        wait_valid("par_nobreak");
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL par_nobreak_frame got %b want 1", frame_err); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL par_nobreak_break got %b want 0", break_det); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_nobreak_perr got %b want 1", parity_err); end
        consume();
        parity_en = 1'b0;
        hold_bits(1);
    endtask

    task automatic test_break();
        @(negedge clk);
        rx = 1'b0;
        hold_bits(12);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL break_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL break_data got %h want 00", rx_data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_frame got %b want 1", frame_err); end
        checks++; if (break_det !== 1'b1) begin errors++; $display("FAIL break_det got %b want 1", break_det); end
        checks++; if (dut.state_q !== ST_WAIT_HIGH) begin errors++; $display("FAIL break_state got %0d want %0d", dut.state_q, ST_WAIT_HIGH); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL break_release_state got %0d want %0d", dut.state_q, ST_IDLE); end
        consume();
        hold_bits(2);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_single_frame got %b want 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0);
        wait_valid("frame_err");
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ferr_data got %h want 12", rx_data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_err); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL ferr_break got %b want 0", break_det); end
        consume();
        hold_bits(1);
    endtask

    task automatic test_overrun();
        int base;
        base = ov_count;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        wait_valid("overrun_first");
        checks++; if (ov_count != base) begin errors++; $display("FAIL ovr_first got %0d want %0d", ov_count - base, 0); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        hold_bits(1);
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h want 11", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
        checks++; if (ov_count - base != 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ov_count - base); end
        consume();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        hold_bits(2);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL glitch_state got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rx = 1'b0;
        hold_bits(1);
        rx = 1'b1;
        hold_bits(3);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", rx_data); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", dut.state_q, ST_IDLE); end
        reset_n = 1'b1;
        hold_bits(10);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_valid("rstmid");
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_new_data got %h want 3c", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame got %b want 0", frame_err); end
        consume();
    endtask

    task automatic test_back_to_back();
        int base;
        base = got_q.size();
        @(negedge clk);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        hold_bits(1);
        rx_ready = 1'b0;
        checks++; if (got_q.size() - base != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got_q.size() - base); end
        if (got_q.size() - base >= 2) begin
            checks++; if (got_q[base] !== 8'h81) begin errors++; $display("FAIL b2b_first got %h want 81", got_q[base]); end
            checks++; if (got_q[base + 1] !== 8'h7E) begin errors++; $display("FAIL b2b_second got %h want 7e", got_q[base + 1]); end
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b want 0", rx_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
